// File: rtl/ysyx_22040038_pkg.sv
// Shared definitions for the NPC control sequencer: RV64I major opcodes,
// sequencer state encoding and the reset value of the instruction register.
package ysyx_22040038_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/ysyx_22040038_ctrl_seq_if.sv
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the memory side (slave).
interface ysyx_22040038_ctrl_seq_if;

  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/ysyx_22040038_op_class.sv
// Combinational opcode classifier: legality, memory access kind, ebreak
// detection and whether the instruction writes a destination register.
module ysyx_22040038_op_class
  import ysyx_22040038_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [11:0] imm12,
  input  logic [4:0]  rd,
  output logic        legal,
  output logic        is_mem,
  output logic        is_store,
  output logic        is_ebreak,
  output logic        writes_rd
);

  logic no_rd_write;

  // Classify the major opcode; SYSTEM with imm12 != 1 behaves as a nop.
  always_comb begin
    legal       = 1'b0;
    no_rd_write = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
      OP_IMM, OP_IMM32, OP_REG, OP_REG32: legal = 1'b1;
      OP_BRANCH, OP_STORE, OP_SYSTEM: begin
        legal       = 1'b1;
        no_rd_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    is_store  = (op == OP_STORE);
    is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    is_ebreak = (op == OP_SYSTEM) && (imm12 == 12'd1);
    writes_rd = legal && !no_rd_write && (rd != 5'd0);
  end

endmodule

// File: rtl/ysyx_22040038_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64I NPC core.
// Owns the instruction register, the memory handshakes, the retire counter
// and the sticky halt/halt_good result.
module ysyx_22040038_ctrl_seq
  import ysyx_22040038_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_22040038_ctrl_seq_if.master  bus,
  output logic [31:0]               ir,
  input  logic [6:0]                op,
  input  logic [4:0]                rd,
  input  logic [11:0]               imm12,
  input  logic [63:0]               a0,
  output logic                      rf_wen,
  output logic                      pc_we,
  output logic                      halt,
  output logic                      halt_good,
  output logic [CNT_W-1:0]          instret,
  output logic [2:0]                state_o
);

  // Last wait value at which a missing ack still does not time out; an ack
  // in the cycle the count would reach MEM_TIMEOUT wins over the timeout.
  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  ctrl_state_t      state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [31:0]      ir_q, ir_d;
  logic             halt_good_q, halt_good_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic cls_legal, cls_is_mem, cls_is_store, cls_is_ebreak, cls_writes_rd;
  logic wait_expired;

  ysyx_22040038_op_class u_op_class (
    .op        (op),
    .imm12     (imm12),
    .rd        (rd),
    .legal     (cls_legal),
    .is_mem    (cls_is_mem),
    .is_store  (cls_is_store),
    .is_ebreak (cls_is_ebreak),
    .writes_rd (cls_writes_rd)
  );

  assign wait_expired = (wait_q == WAIT_LAST);

  // State, wait counter, instruction register and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      wait_q      <= '0;
      ir_q        <= NOP;
      halt_good_q <= 1'b0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      ir_q        <= ir_d;
      halt_good_q <= halt_good_d;
      instret_q   <= instret_d;
    end
  end

  // Next-state, wait-count and retire/result updates.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    ir_d        = ir_q;
    halt_good_d = halt_good_q;
    instret_d   = instret_q;
    unique case (state_q)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d     = ST_HALT;
          halt_good_d = 1'b0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DECODE: begin
        if (cls_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d     = ST_HALT;
          halt_good_d = 1'b0;
        end
      end
      ST_EXEC: begin
        if (cls_is_mem) begin
          state_d = ST_MEM;
        end else if (cls_is_ebreak) begin
          state_d     = ST_HALT;
          halt_good_d = (a0 == 64'd0);
          instret_d   = instret_q + CNT_ONE;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          state_d = ST_WB;
        end else if (wait_expired) begin
          state_d     = ST_HALT;
          halt_good_d = 1'b0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WB: begin
        instret_d = instret_q + CNT_ONE;
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d     = ST_HALT;
        halt_good_d = 1'b0;
      end
    endcase
    if (state_d != state_q) begin
      wait_d = '0;
    end
  end

  // Moore strobes decoded from the current state.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    rf_wen       = 1'b0;
    pc_we        = 1'b0;
    halt         = 1'b0;
    unique case (state_q)
      ST_FETCH: bus.imem_req = 1'b1;
      ST_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = cls_is_store;
      end
      ST_WB: begin
        pc_we  = 1'b1;
        rf_wen = cls_writes_rd;
      end
      ST_HALT: halt = 1'b1;
      default: halt = 1'b0;
    endcase
  end

  assign ir        = ir_q;
  assign halt_good = halt_good_q;
  assign instret   = instret_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ysyx_22040038_ctrl_seq.sv
// Bench for the NPC control sequencer: acts as memory and decoder, drives
// random instruction streams with random ack latencies, and compares every
// cycle against a per-instruction reference model of the pipeline phases.
module tb_ysyx_22040038_ctrl_seq;

  localparam int CNT_W = 64;
  localparam logic [6:0] LEGAL [12] = '{
    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
    7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011, 7'b0111011, 7'b1110011
  };
  localparam logic [6:0] M_BRANCH = 7'b1100011;
  localparam logic [6:0] M_LOAD   = 7'b0000011;
  localparam logic [6:0] M_STORE  = 7'b0100011;
  localparam logic [6:0] M_SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ysyx_22040038_ctrl_seq_if bus_if();

  logic [31:0]      ir;
  logic [6:0]       op;
  logic [4:0]       rd;
  logic [11:0]      imm12;
  logic [63:0]      a0;
  logic             rf_wen, pc_we, halt, halt_good;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state_o;

  // Decoder stand-in: fields sliced straight from the instruction register.
  assign op    = ir[6:0];
  assign rd    = ir[11:7];
  assign imm12 = ir[31:20];

  ysyx_22040038_ctrl_seq #(.MEM_TIMEOUT(255), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .ir        (ir),
    .op        (op),
    .rd        (rd),
    .imm12     (imm12),
    .a0        (a0),
    .rf_wen    (rf_wen),
    .pc_we     (pc_we),
    .halt      (halt),
    .halt_good (halt_good),
    .instret   (instret),
    .state_o   (state_o)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] exp_instret = '0;
  logic        exp_hg = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    for (int i = 0; i < 12; i++) if (LEGAL[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = LEGAL[$urandom_range(0, 11)];
    if (w[6:0] == M_SYSTEM && w[31:20] == 12'd1) w[31:20] = 12'd0;
    return w;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 19) == 0) ? 254 : int'($urandom_range(0, 3));
  endfunction

  // One clock cycle: drive memory inputs, check outputs, advance.
  task automatic cyc(input string tag, input int st, input bit ireq, input bit dreq,
                     input bit dwe, input bit rfw, input bit pcw, input bit hlt,
                     input bit iack, input bit dack, input logic [31:0] rdata);
    bus_if.imem_ack   = iack;
    bus_if.dmem_ack   = dack;
    bus_if.imem_rdata = rdata;
    chk({tag, ".state"}, 64'(state_o), 64'(st));
    chk({tag, ".imem_req"}, 64'(bus_if.imem_req), 64'(ireq));
    chk({tag, ".dmem_req"}, 64'(bus_if.dmem_req), 64'(dreq));
    if (dreq) chk({tag, ".dmem_we"}, 64'(bus_if.dmem_we), 64'(dwe));
    chk({tag, ".rf_wen"}, 64'(rf_wen), 64'(rfw));
    chk({tag, ".pc_we"}, 64'(pc_we), 64'(pcw));
    chk({tag, ".halt"}, 64'(halt), 64'(hlt));
    @(posedge clk);
    #1;
  endtask

  // Reference model of one instruction's life, from its bits and ack delays.
  task automatic run_instr(input string tag, input logic [31:0] w, input int iw,
                           input int dw, input logic [63:0] a0v, output bit halted);
    logic [6:0] o;
    bit lg, is_ld, is_st, is_sys, is_ebk, wr, acked;
    o      = w[6:0];
    lg     = is_legal(o);
    is_ld  = (o == M_LOAD);
    is_st  = (o == M_STORE);
    is_sys = (o == M_SYSTEM);
    is_ebk = is_sys && (w[31:20] == 12'd1);
    wr     = lg && !(o == M_BRANCH || is_st || is_sys) && (w[11:7] != 5'd0);
    halted = 1'b0;
    a0     = a0v;
    acked  = 1'b0;
    for (int c = 0; c < 255 && !acked; c++) begin
      acked = (c == iw);
      cyc({tag, ".fetch"}, 0, 1, 0, 0, 0, 0, 0, acked, rnd1(), acked ? w : $urandom);
    end
    if (!acked) begin
      halted = 1'b1;
      exp_hg = 1'b0;
      return;
    end
    chk({tag, ".ir"}, 64'(ir), 64'(w));
    cyc({tag, ".decode"}, 1, 0, 0, 0, 0, 0, 0, rnd1(), rnd1(), $urandom);
    if (!lg) begin
      halted = 1'b1;
      exp_hg = 1'b0;
      return;
    end
    cyc({tag, ".exec"}, 2, 0, 0, 0, 0, 0, 0, rnd1(), rnd1(), $urandom);
    if (is_ebk) begin
      exp_instret++;
      exp_hg = (a0v == 64'd0);
      halted = 1'b1;
      return;
    end
    if (is_ld || is_st) begin
      acked = 1'b0;
      for (int c = 0; c < 255 && !acked; c++) begin
        acked = (c == dw);
        cyc({tag, ".mem"}, 3, 0, 1, is_st, 0, 0, 0, rnd1(), acked, $urandom);
      end
      if (!acked) begin
        halted = 1'b1;
        exp_hg = 1'b0;
        return;
      end
    end
    cyc({tag, ".wb"}, 4, 0, 0, 0, wr, 1, 0, rnd1(), rnd1(), $urandom);
    exp_instret++;
    chk({tag, ".instret"}, instret, exp_instret);
  endtask

  task automatic halt_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".halt_good"}, 64'(halt_good), 64'(exp_hg));
      chk({tag, ".instret"}, instret, exp_instret);
      a0 = {$urandom, $urandom};
      cyc(tag, 5, 0, 0, 0, 0, 0, 1, rnd1(), rnd1(), $urandom);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus_if.imem_ack = 1'b0;
    bus_if.dmem_ack = 1'b0;
    #1;
    chk({tag, ".state"}, 64'(state_o), 64'd0);
    chk({tag, ".imem_req"}, 64'(bus_if.imem_req), 64'd1);
    chk({tag, ".dmem_req"}, 64'(bus_if.dmem_req), 64'd0);
    chk({tag, ".dmem_we"}, 64'(bus_if.dmem_we), 64'd0);
    chk({tag, ".rf_wen"}, 64'(rf_wen), 64'd0);
    chk({tag, ".pc_we"}, 64'(pc_we), 64'd0);
    chk({tag, ".halt"}, 64'(halt), 64'd0);
    chk({tag, ".halt_good"}, 64'(halt_good), 64'd0);
    chk({tag, ".instret"}, instret, 64'd0);
    chk({tag, ".ir"}, 64'(ir), 64'h13);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_instret = '0;
    exp_hg = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    bus_if.imem_ack   = 1'b0;
    bus_if.dmem_ack   = 1'b0;
    bus_if.imem_rdata = '0;
    a0 = '0;
    #2;
    do_reset("rst0");

    run_instr("addi", 32'h00500093, 0, 0, 64'd0, h);
    run_instr("lw", 32'h0000a103, 0, 3, 64'd0, h);
    run_instr("sw", 32'h0020a223, 1, 0, 64'd0, h);
    run_instr("fetch_edge", 32'h00500093, 254, 0, 64'd0, h);
    run_instr("mem_edge", 32'h0000a103, 0, 254, 64'd0, h);
    run_instr("csr_nop", 32'h00000073, 0, 0, 64'd0, h);
    for (int i = 0; i < 120; i++)
      run_instr("rnd", rand_word(), rand_wait(), rand_wait(), {$urandom, $urandom}, h);

    run_instr("ebreak_a0_0", 32'h00100073, 0, 0, 64'd0, h);
    halt_idle("halt_good", 8);
    do_reset("rst1");

    run_instr("addi2", 32'h00500093, 2, 0, 64'd0, h);
    run_instr("ebreak_a0_7", 32'h00100073, 0, 0, 64'd7, h);
    halt_idle("halt_bad", 8);
    do_reset("rst2");

    run_instr("addi3", 32'h00500093, 0, 0, 64'd0, h);
    run_instr("illegal", 32'hffffffff, 0, 0, 64'd0, h);
    halt_idle("halt_ill", 6);
    do_reset("rst3");

    run_instr("fetch_tmo", 32'h00500093, 255, 0, 64'd0, h);
    halt_idle("halt_ftmo", 4);
    do_reset("rst4");

    run_instr("addi4", 32'h00500093, 0, 0, 64'd0, h);
    run_instr("mem_tmo", 32'h0000a103, 0, 255, 64'd0, h);
    halt_idle("halt_mtmo", 4);
    do_reset("rst5");

    // Reset in the middle of a load, then a stray dmem_ack right after.
    cyc("rmem.fetch", 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0000a103);
    cyc("rmem.decode", 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    cyc("rmem.exec", 2, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    cyc("rmem.mem", 3, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("rmem.dmem_req", 64'(bus_if.dmem_req), 64'd1);
    do_reset("rst_in_mem");
    cyc("post_rst", 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    run_instr("after_rst", 32'h00500093, 0, 0, 64'd0, h);

    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      int n;
      n = int'($urandom_range(2, 5));
      for (int i = 0; i < n; i++)
        run_instr("rnd_t", rand_word(), rand_wait(), rand_wait(), {$urandom, $urandom}, h);
      w = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          w[6:0] = M_SYSTEM;
          w[31:20] = 12'd1;
          run_instr("term_ebk", w, 0, 0, rnd1() ? 64'd0 : {$urandom, $urandom | 32'd1}, h);
        end
        1: begin
          while (is_legal(w[6:0])) w[6:0] = 7'($urandom);
          run_instr("term_ill", w, 1, 0, 64'd0, h);
        end
        default: begin
          w = 32'h00100073;
          run_instr("term_ebk0", w, 0, 0, 64'd0, h);
        end
      endcase
      halt_idle("term_halt", 5);
      do_reset("rst_t");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22040038_ctrl_seq.md
Name: ysyx_22040038_ctrl_seq

Overview:
Multi-cycle control sequencer for the single-issue RV64I NPC core.
- Fetches each instruction over an instruction-memory req/ack handshake and holds it in the instruction register that feeds the decoder.
- Classifies the decoded opcode and steps the datapath through FETCH/DECODE/EXEC/MEM/WB.
- Issues register-file write enable, PC update and data-memory request.
- Halts the core on ebreak, an illegal opcode or a memory timeout, and reports the result to the simulation environment.

Parameters:
- MEM_TIMEOUT, 255: max wait cycles for any ack before fault halt; 8-bit wait counter.
- CNT_W, 64: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  fetched instruction
- ir  out  32  instruction register, drives decoder instr_i
- op  in  7  decoded opcode
- rd  in  5  decoded destination register
- imm12  in  12  decoded immI[11:0]
- a0  in  64  current x10 value, for the halt code
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  in  1  data access complete
- rf_wen  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- halt  out  1  core stopped (sticky)
- halt_good  out  1  valid with halt: ebreak and a0 == 0
- instret  out  CNT_W  retired-instruction count
- state_o  out  3  current state, debug

Behaviour:
- Reset value of every output: imem_req=1, all other strobes 0, ir=32'h00000013 (nop), halt=0, halt_good=0, instret=0, state=FETCH. Reset is honoured mid-transaction; any outstanding ack after reset release is ignored unless the block is in the matching state.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir<=imem_rdata, go to DECODE.
  - Wait counter increments each non-ack cycle; reaching MEM_TIMEOUT goes to HALT with halt_good=0.
- DECODE, one cycle, classifies op:
  - Legal: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0011011, 0110011, 0111011, 1110011.
  - Any other op: go to HALT with halt_good=0.
  - Otherwise go to EXEC.
- EXEC, one cycle:
  - load (0000011) or store (0100011): go to MEM.
  - SYSTEM with imm12==1 (ebreak): go to HALT with halt_good=(a0==0). The instruction still counts as retired.
  - SYSTEM with imm12!=1: treated as nop and goes to WB.
  - All others: go to WB.
- MEM:
  - dmem_req=1 with dmem_we=(store) until dmem_ack, then go to WB.
  - Same timeout rule as FETCH.
- WB, one cycle:
  - pc_we=1 and instret increments.
  - rf_wen=1 except for branch, store and SYSTEM, or when rd==0.
  - Go to FETCH.
- HALT: absorbing until reset. All strobes 0, halt=1, halt_good frozen; acks ignored.
- Outputs are Moore, decoded from state. halt_good and instret are registered.
- The wait counter clears on every state entry.
- Latency with zero-wait acks: ALU/branch/jump = 4 cycles per instruction, load/store = 5 cycles.
- Strobe rules:
  - imem_req and dmem_req are never high together.
  - rf_wen and pc_we are single-cycle pulses.
  - An ack arriving in the same cycle the counter hits MEM_TIMEOUT counts as success.
- instret wraps modulo 2^CNT_W.

Decomposition:
- Shared package ysyx_22040038_pkg holds: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_IMM32, OP_REG, OP_REG32, OP_SYSTEM), state enum ctrl_state_t, NOP constant 32'h00000013.
- One sub-module, ysyx_22040038_op_class: combinational op/imm12 to {legal, is_mem, is_store, is_ebreak, writes_rd}, reused by the verification model.
- The DPI c_trap call stays in the decoder; this block only exports halt/halt_good.

Test Plan:
- Reset, then fetch addi x1,x0,5 (32'h00500093) with immediate ack -> states 0,1,2,4; rf_wen and pc_we pulse together in cycle 4; instret=1; next cycle imem_req=1.
- lw x2,0(x1) (32'h0000a103), dmem_ack after 3 wait cycles -> dmem_req=1, dmem_we=0 for 4 cycles; WB one cycle after ack; total 8 cycles; rf_wen=1.
- sw x2,4(x1) (32'h0020a223) -> dmem_we=1 during MEM; rf_wen=0 in WB; pc_we=1.
- ebreak (32'h00100073) with a0=0 -> HALT after EXEC; halt=1, halt_good=1, instret incremented. Repeat with a0=7 -> halt_good=0. Later imem_ack pulses produce no strobes.
- Illegal word 32'hffffffff -> HALT from DECODE, halt_good=0, instret unchanged. Separately, hold imem_ack low for 255 cycles -> HALT, halt_good=0.
- Assert rst_n low while in MEM with dmem_req=1 -> all outputs return to reset values immediately, state=FETCH. A dmem_ack in the first post-reset cycle is ignored.
